// File: rtl/ot_demux_route_pkg.sv
// Shared helpers and limits for the 1-to-N buffered stream router.
// Optional feature macro (see top): OT_DEMUX_ROUTE_ERR_DROP_EN.
package ot_demux_route_pkg;

  localparam int MAX_OUT_CNT   = 8;
  localparam int MAX_BUF_DEPTH = 8;

  // $clog2 that never returns 0, so single-bit selects/pointers stay legal
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int DST_W_MAX   = clog2_min1(MAX_OUT_CNT);
  localparam int USAGE_W_MAX = $clog2(MAX_BUF_DEPTH) + 1;

  typedef logic [DST_W_MAX-1:0]   dst_t;
  typedef logic [USAGE_W_MAX-1:0] usage_t;

endpackage

// File: rtl/ot_demux_obuf_rstn.sv
// One per-output FIFO of the router: registered head, no bypass, storage cleared by reset.
module ot_demux_obuf_rstn
  import ot_demux_route_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int BUF_DEPTH  = 2
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         push,
  input  logic [DATA_WIDTH-1:0]        push_data,
  input  logic                         pop_rdy,
  output logic                         vld,
  output logic                         full,
  output logic [$clog2(BUF_DEPTH):0]   usage,
  output logic [DATA_WIDTH-1:0]        head_data
);

  localparam int PW = clog2_min1(BUF_DEPTH);
  localparam int UW = $clog2(BUF_DEPTH) + 1;

  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [UW-1:0]         count;
  logic                  do_push;
  logic                  do_pop;

  assign full      = (count == UW'(BUF_DEPTH));
  assign vld       = (count != '0);
  assign usage     = count;
  assign head_data = mem[rd_ptr];

  // a full FIFO refuses the push even when it pops in the same cycle
  assign do_push = push & ~full;
  assign do_pop  = pop_rdy & vld;

  // BUF_DEPTH is a power of two, so the pointers wrap naturally
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int k = 0; k < BUF_DEPTH; k++) mem[k] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ot_demux_route_rstn.sv
// 1-to-N stream router: each beat is steered by in_dst into that output's FIFO.
// OT_DEMUX_ROUTE_ERR_DROP_EN: drop illegal in_dst beats and flag sticky err_dst.
module ot_demux_route_rstn
  import ot_demux_route_pkg::*;
#(
  parameter int OUT_CNT    = 4,
  parameter int DATA_WIDTH = 128,
  parameter int BUF_DEPTH  = 2,
  parameter int DST_W      = clog2_min1(OUT_CNT)
) (
  input  logic                                       clk,
  input  logic                                       rstn,
  input  logic                                       in_vld,
  output logic                                       in_rdy,
  input  logic [DST_W-1:0]                           in_dst,
  input  logic [DATA_WIDTH-1:0]                      in_data,
  output logic [OUT_CNT-1:0]                         out_vld,
  input  logic [OUT_CNT-1:0]                         out_rdy,
  output logic [OUT_CNT-1:0][DATA_WIDTH-1:0]         out_data,
  output logic [OUT_CNT-1:0][$clog2(BUF_DEPTH):0]    out_usage,
`ifdef OT_DEMUX_ROUTE_ERR_DROP_EN
  output logic                                       err_dst,
`endif
  output logic                                       idle
);

  logic               dst_legal;
  logic [DST_W-1:0]   dst_sel;
  logic               route_en;
  logic [OUT_CNT-1:0] full;
  logic [OUT_CNT-1:0] push;

  // in_rdy depends only on in_dst and registered counts, never on out_rdy
  always_comb begin
    dst_legal = (32'(in_dst) < 32'(OUT_CNT));
    dst_sel   = dst_legal ? in_dst : DST_W'(OUT_CNT - 1);
`ifdef OT_DEMUX_ROUTE_ERR_DROP_EN
    in_rdy    = dst_legal ? ~full[dst_sel] : 1'b1;
    route_en  = in_vld & in_rdy & dst_legal;
`else
    in_rdy    = ~full[dst_sel];
    route_en  = in_vld & in_rdy;
`endif
    for (int i = 0; i < OUT_CNT; i++) begin
      push[i] = route_en && (dst_sel == DST_W'(i));
    end
  end

`ifdef OT_DEMUX_ROUTE_ERR_DROP_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_dst <= 1'b0;
    end else if (in_vld && !dst_legal) begin
      err_dst <= 1'b1;
    end
  end
`endif

  for (genvar g = 0; g < OUT_CNT; g++) begin : g_obuf
    ot_demux_obuf_rstn #(
      .DATA_WIDTH (DATA_WIDTH),
      .BUF_DEPTH  (BUF_DEPTH)
    ) u_obuf (
      .clk       (clk),
      .rstn      (rstn),
      .push      (push[g]),
      .push_data (in_data),
      .pop_rdy   (out_rdy[g]),
      .vld       (out_vld[g]),
      .full      (full[g]),
      .usage     (out_usage[g]),
      .head_data (out_data[g])
    );
  end

  assign idle = ~|out_vld;

endmodule

// File: tb/tb_ot_demux_route_rstn.sv
// Directed bench for the buffered 1-to-N router (4-output and 3-output instances).
module tb_ot_demux_route_rstn;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic              in_vld = 1'b0;
  logic              in_rdy;
  logic [1:0]        in_dst = '0;
  logic [127:0]      in_data = '0;
  logic [3:0]        out_vld;
  logic [3:0]        out_rdy = '0;
  logic [3:0][127:0] out_data;
  logic [3:0][1:0]   out_usage;
  logic              idle;
  logic              err_main;

  logic              in_vld3 = 1'b0;
  logic              in_rdy3;
  logic [1:0]        in_dst3 = '0;
  logic [7:0]        in_data3 = '0;
  logic [2:0]        out_vld3;
  logic [2:0]        out_rdy3 = '0;
  logic [2:0][7:0]   out_data3;
  logic [2:0][1:0]   out_usage3;
  logic              idle3;
  logic              err3;

  ot_demux_route_rstn #(.OUT_CNT(4), .DATA_WIDTH(128), .BUF_DEPTH(2)) u_dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_vld    (in_vld),
    .in_rdy    (in_rdy),
    .in_dst    (in_dst),
    .in_data   (in_data),
    .out_vld   (out_vld),
    .out_rdy   (out_rdy),
    .out_data  (out_data),
    .out_usage (out_usage),
`ifdef OT_DEMUX_ROUTE_ERR_DROP_EN
    .err_dst   (err_main),
`endif
    .idle      (idle)
  );

  ot_demux_route_rstn #(.OUT_CNT(3), .DATA_WIDTH(8), .BUF_DEPTH(2)) u_dut3 (
    .clk       (clk),
    .rstn      (rstn),
    .in_vld    (in_vld3),
    .in_rdy    (in_rdy3),
    .in_dst    (in_dst3),
    .in_data   (in_data3),
    .out_vld   (out_vld3),
    .out_rdy   (out_rdy3),
    .out_data  (out_data3),
    .out_usage (out_usage3),
`ifdef OT_DEMUX_ROUTE_ERR_DROP_EN
    .err_dst   (err3),
`endif
    .idle      (idle3)
  );

`ifndef OT_DEMUX_ROUTE_ERR_DROP_EN
  assign err_main = 1'b0;
  assign err3     = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       vld;
    logic [1:0] dst;
    logic [7:0] data;
    logic [3:0] rdy;
    logic       e_rdy;
    logic [3:0] e_vld;
    logic [7:0] e_use;
    logic       e_idle;
    int         c_idx;
    logic [7:0] e_data;
  } vec_t;

  vec_t vt[12];
  logic [127:0] exp_q[4][$];
  int recv[4];

  initial begin
    // e_use packs usage3..usage0 as 2-bit fields
    vt[0]  = '{1'b1, 2'd2, 8'hA5, 4'b1111, 1'b1, 4'b0100, 8'h10, 1'b0, 2, 8'hA5};
    vt[1]  = '{1'b0, 2'd0, 8'h00, 4'b1111, 1'b1, 4'b0000, 8'h00, 1'b1, 2, 8'h00};
    vt[2]  = '{1'b1, 2'd1, 8'h11, 4'b1101, 1'b1, 4'b0010, 8'h04, 1'b0, 1, 8'h11};
    vt[3]  = '{1'b1, 2'd1, 8'h22, 4'b1101, 1'b1, 4'b0010, 8'h08, 1'b0, 1, 8'h11};
    vt[4]  = '{1'b1, 2'd1, 8'h33, 4'b1101, 1'b0, 4'b0010, 8'h08, 1'b0, 1, 8'h11};
    vt[5]  = '{1'b1, 2'd3, 8'h44, 4'b0101, 1'b1, 4'b1010, 8'h48, 1'b0, 3, 8'h44};
    vt[6]  = '{1'b1, 2'd1, 8'h33, 4'b1111, 1'b0, 4'b0010, 8'h04, 1'b0, 1, 8'h22};
    vt[7]  = '{1'b1, 2'd1, 8'h33, 4'b1111, 1'b1, 4'b0010, 8'h04, 1'b0, 1, 8'h33};
    vt[8]  = '{1'b0, 2'd0, 8'h00, 4'b1111, 1'b1, 4'b0000, 8'h00, 1'b1, 0, 8'h00};
    vt[9]  = '{1'b1, 2'd0, 8'h01, 4'b0000, 1'b1, 4'b0001, 8'h01, 1'b0, 0, 8'h01};
    vt[10] = '{1'b1, 2'd3, 8'h03, 4'b0000, 1'b1, 4'b1001, 8'h41, 1'b0, 3, 8'h03};
    vt[11] = '{1'b0, 2'd0, 8'h00, 4'b1001, 1'b1, 4'b0000, 8'h00, 1'b1, 0, 8'h00};

    // reset then idle
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("rst_out_vld", 128'(out_vld), 128'h0);
    check("rst_usage", 128'(out_usage), 128'h0);
    check("rst_idle", 128'(idle), 128'h1);
    check("rst_in_rdy", 128'(in_rdy), 128'h1);
    check("rst_out_data0", out_data[0], 128'h0);
    check("rst_err", 128'(err_main), 128'h0);

    // routing, backpressure, full-with-pop
    for (int i = 0; i < 12; i++) begin
      in_vld  = vt[i].vld;
      in_dst  = vt[i].dst;
      in_data = 128'(vt[i].data);
      out_rdy = vt[i].rdy;
      #1;
      check($sformatf("v%0d_in_rdy", i), 128'(in_rdy), 128'(vt[i].e_rdy));
      @(negedge clk);
      check($sformatf("v%0d_out_vld", i), 128'(out_vld), 128'(vt[i].e_vld));
      check($sformatf("v%0d_usage", i), 128'(out_usage), 128'(vt[i].e_use));
      check($sformatf("v%0d_idle", i), 128'(idle), 128'(vt[i].e_idle));
      if (vt[i].e_vld[vt[i].c_idx])
        check($sformatf("v%0d_data%0d", i, vt[i].c_idx), out_data[vt[i].c_idx], 128'(vt[i].e_data));
    end
    in_vld = 1'b0;

    // streaming round-robin, all ready
    out_rdy = 4'b1111;
    for (int o = 0; o < 4; o++) recv[o] = 0;
    for (int i = 0; i < 104; i++) begin
      for (int o = 0; o < 4; o++) begin
        if (out_vld[o]) begin
          recv[o]++;
          if (exp_q[o].size() == 0) check($sformatf("stream_extra%0d", o), out_data[o], 128'hX);
          else check($sformatf("stream_data%0d", o), out_data[o], exp_q[o].pop_front());
        end
      end
      if (i < 100) begin
        in_vld  = 1'b1;
        in_dst  = 2'(i % 4);
        in_data = 128'(32'h1000 + i);
        #1;
        check($sformatf("stream_in_rdy%0d", i), 128'(in_rdy), 128'h1);
        if (in_rdy) exp_q[i % 4].push_back(128'(32'h1000 + i));
      end else begin
        in_vld = 1'b0;
      end
      @(negedge clk);
    end
    for (int o = 0; o < 4; o++) check($sformatf("stream_count%0d", o), 128'(recv[o]), 128'd25);
    check("stream_idle", 128'(idle), 128'h1);

    // illegal destination on the 3-output instance
    in_vld3 = 1'b1; in_dst3 = 2'd3; in_data3 = 8'h5A; out_rdy3 = 3'b000;
    #1;
    check("ill_in_rdy", 128'(in_rdy3), 128'h1);
    @(negedge clk);
    in_vld3 = 1'b0;
`ifdef OT_DEMUX_ROUTE_ERR_DROP_EN
    check("ill_out_vld", 128'(out_vld3), 128'h0);
    check("ill_err", 128'(err3), 128'h1);
    check("ill_idle", 128'(idle3), 128'h1);
`else
    check("ill_out_vld", 128'(out_vld3), 128'b100);
    check("ill_data2", 128'(out_data3[2]), 128'h5A);
    check("ill_usage2", 128'(out_usage3[2]), 128'h1);
`endif
    in_vld3 = 1'b1; in_dst3 = 2'd0; in_data3 = 8'h77;
    @(negedge clk);
    in_vld3 = 1'b0;
    check("leg3_data0", 128'(out_data3[0]), 128'h77);
`ifdef OT_DEMUX_ROUTE_ERR_DROP_EN
    check("leg3_out_vld", 128'(out_vld3), 128'b001);
    check("err_sticky", 128'(err3), 128'h1);
`else
    check("leg3_out_vld", 128'(out_vld3), 128'b101);
`endif

    // async reset mid-burst
    out_rdy = 4'b0000;
    in_vld = 1'b1; in_dst = 2'd0; in_data = 128'hBEEF;
    @(negedge clk);
    in_dst = 2'd1;
    @(negedge clk);
    in_vld = 1'b0;
    check("burst_usage", 128'(out_usage), 128'h05);
    #2 rstn = 1'b0;
    #1;
    check("arst_usage", 128'(out_usage), 128'h0);
    check("arst_out_vld", 128'(out_vld), 128'h0);
    check("arst_idle", 128'(idle), 128'h1);
    check("arst_data0", out_data[0], 128'h0);
    check("arst_vld3", 128'(out_vld3), 128'h0);
    check("arst_err3", 128'(err3), 128'h0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("post_rst_in_rdy", 128'(in_rdy), 128'h1);
    check("post_rst_idle", 128'(idle), 128'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
